// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer: 16x oversampled start/data/stop recovery, 5..DATA_MAX data bits.
module uart_rx_framer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_MAX   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_tick,
  input  logic                rx,
  input  logic [3:0]          uart_data_width,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    W_MIN    = 4'd5;
  localparam logic [3:0]    W_MAX    = 4'(DATA_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t              state, state_nxt;
  logic [1:0]          sync_q;
  logic                rx_s;
  logic [TW-1:0]       tick_cnt, tick_nxt;
  logic [3:0]          bit_cnt, bit_nxt;
  logic [3:0]          width_q, width_nxt, width_clamped;
  logic [DATA_MAX-1:0] shift_q, shift_nxt, rx_data_nxt;
  logic                rx_valid_nxt, frame_err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];
  assign busy = (state != IDLE);

  always_comb begin
    if (uart_data_width < W_MIN)      width_clamped = W_MIN;
    else if (uart_data_width > W_MAX) width_clamped = W_MAX;
    else                              width_clamped = uart_data_width;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      width_q   <= W_MAX;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      width_q   <= width_nxt;
      shift_q   <= shift_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tick_nxt      = tick_cnt;
    bit_nxt       = bit_cnt;
    width_nxt     = width_q;
    shift_nxt     = shift_q;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          width_nxt = width_clamped;
          state_nxt = START;
        end
      end
      START: begin
        // Re-check the line at the start-bit centre to reject glitches.
        if (baud_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt  = '0;
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_END) begin
            tick_nxt  = '0;
            shift_nxt = {rx_s, shift_q[DATA_MAX-1:1]};
            bit_nxt   = bit_cnt + 4'd1;
            if (bit_cnt + 4'd1 == width_q) state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_END) begin
            tick_nxt    = '0;
            // Narrow frames sit in the top bits of the shifter; drop them to bit 0.
            rx_data_nxt = shift_q >> (W_MAX - width_q);
            if (rx_s) begin
              rx_valid_nxt = 1'b1;
              state_nxt    = IDLE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - self-checking bench for uart_rx_framer against a frame-level model.
module tb_uart_rx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] uart_data_width = 4'd8;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic       after_strobe = 1'b0;
  logic       after_err = 1'b0;

  uart_rx_framer #(.OVERSAMPLE(16), .DATA_MAX(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_tick      (baud_tick),
    .rx             (rx),
    .uart_data_width(uart_data_width),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      div++;
      baud_tick = (div % 4 == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampw(input int w);
    if (w < 5) return 5;
    if (w > 8) return 8;
    return w;
  endfunction

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_tick) k++;
    end
    @(negedge clk);
  endtask

  // Model: the receiver takes the first w wire bits after the start bit as data,
  // and wire bit w as the stop bit, with w fixed at start time.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop,
                            input int hold_low, input int chg_bit, input logic [3:0] chg_w);
    logic [15:0] wbits;
    exp_t        e;
    int          w;
    wbits = '1;
    for (int i = 0; i < nbits; i++) wbits[i] = data[i];
    wbits[nbits] = stop;
    w = clampw(int'(uart_data_width));
    e.data = '0;
    for (int i = 0; i < w; i++) e.data[i] = wbits[i];
    e.err = ~wbits[w];
    exp_q.push_back(e);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) uart_data_width = chg_w;
      rx = data[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(16);
    if (hold_low > 0) wait_ticks(hold_low);
    else rx = 1'b1;
    check("strobe_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        model_data   = 8'h00;
        after_strobe = 1'b0;
      end else if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got valid=%0b err=%0b, expected none at %0t",
                   rx_valid, frame_err, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          model_data = e.data;
          check("strobe_kind", 32'({rx_valid, frame_err}), e.err ? 32'd1 : 32'd2);
        end
        after_strobe = 1'b1;
        after_err    = e_err_of(frame_err);
      end else if (after_strobe) begin
        check("busy_after_strobe", 32'(busy), 32'(after_err));
        after_strobe = 1'b0;
      end
      check("rx_data", 32'(rx_data), 32'(model_data));
    end
  end

  function automatic logic e_err_of(input logic fe);
    return fe;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_ticks(4);

    send_frame(8'hA5, 8, 1'b1, 0, -1, 4'd0);
    check("lit_a5", 32'(rx_data), 32'hA5);
    check("busy_idle_a5", 32'(busy), 32'h0);

    uart_data_width = 4'd5;
    send_frame(8'h13, 5, 1'b1, 0, -1, 4'd0);
    check("lit_13", 32'(rx_data), 32'h13);
    check("lit_13_top", 32'(rx_data[7:5]), 32'h0);
    uart_data_width = 4'd3;
    send_frame(8'h1F, 5, 1'b1, 0, -1, 4'd0);
    check("lit_1f", 32'(rx_data), 32'h1F);

    uart_data_width = 4'd8;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_keep", 32'(rx_data), 32'h1F);
    send_frame(8'h3C, 8, 1'b1, 0, -1, 4'd0);
    check("lit_3c", 32'(rx_data), 32'h3C);

    send_frame(8'hFF, 8, 1'b0, 40, -1, 4'd0);
    check("break_busy", 32'(busy), 32'h1);
    check("lit_ff", 32'(rx_data), 32'hFF);
    rx = 1'b1;
    wait_ticks(4);
    check("break_exit_busy", 32'(busy), 32'h0);
    send_frame(8'h01, 8, 1'b1, 0, -1, 4'd0);
    check("lit_01", 32'(rx_data), 32'h01);

    send_frame(8'h55, 8, 1'b1, 0, -1, 4'd0);
    check("lit_55", 32'(rx_data), 32'h55);
    send_frame(8'hAA, 8, 1'b1, 0, 3, 4'd6);
    check("lit_aa", 32'(rx_data), 32'hAA);
    wait_ticks(4);
    send_frame(8'h2B, 6, 1'b1, 0, -1, 4'd0);
    check("lit_2b", 32'(rx_data), 32'h2B);

    uart_data_width = 4'd8;
    wait_ticks(4);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(8);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", 32'(rx_data), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(rx_valid), 32'h0);
    check("midrst_err", 32'(frame_err), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(8);
    check("post_rst_busy", 32'(busy), 32'h0);
    send_frame(8'h7E, 8, 1'b1, 0, -1, 4'd0);
    check("lit_7e", 32'(rx_data), 32'h7E);
    wait_ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
